// File: rtl/sumador_acumulador_pipe_if.sv
// Operand/result bundle for sumador_acumulador_pipe.
// valid/enable: valid_in qualifies mode/a/b on an edge where enb=1; valid_out marks a fresh c/carry/overflow.
interface sumador_acumulador_pipe_if #(
  parameter int WIDTH = 4
);
  logic             enb;
  logic             valid_in;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             carry;
  logic             overflow;
  logic             valid_out;

  modport master (
    output enb, valid_in, mode, a, b,
    input  c, carry, overflow, valid_out
  );

  modport slave (
    input  enb, valid_in, mode, a, b,
    output c, carry, overflow, valid_out
  );
endinterface

// File: rtl/sumador_acumulador_pipe.sv
// Two-stage add/sub/accumulate unit with carry/borrow, signed overflow and optional saturation.
// Stage 1 registers the operands; stage 2 computes, registers the result and owns the accumulator.
module sumador_acumulador_pipe #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input logic                    clk,
  input logic                    rst,
  sumador_acumulador_pipe_if.slave bus
);
  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             valid_out_q, valid_out_d;

  logic [WIDTH-1:0] op_x, op_y;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_carry;
  logic             res_ovf;

  // Subtract is a + ~b + 1, so the overflow test compares a against ~b.
  always_comb begin
    op_x = s1_a_q;
    op_y = s1_b_q;
    cin  = 1'b0;
    case (s1_mode_q)
      MODE_ADD: ;
      MODE_SUB: begin
        op_y = ~s1_b_q;
        cin  = 1'b1;
      end
      MODE_ACC: begin
        op_x = acc_q;
        op_y = s1_a_q;
      end
      default: ;
    endcase
    sum       = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, cin};
    res       = sum[WIDTH-1:0];
    res_carry = sum[WIDTH];
    res_ovf   = (op_x[WIDTH-1] == op_y[WIDTH-1]) && (sum[WIDTH-1] != op_x[WIDTH-1]);
    if (s1_mode_q == MODE_SUB) begin
      res_carry = ~sum[WIDTH];
    end
    if (s1_mode_q == MODE_LOAD) begin
      res       = s1_a_q;
      res_carry = 1'b0;
      res_ovf   = 1'b0;
    end
    // Flags keep reporting the unclamped condition; only the value is clamped.
    if (SATURATE && res_carry) begin
      res = (s1_mode_q == MODE_SUB) ? '0 : '1;
    end
  end

  always_comb begin
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_mode_d   = s1_mode_q;
    s1_v_d      = s1_v_q;
    c_d         = c_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    valid_out_d = valid_out_q;
    if (bus.enb) begin
      s1_a_d      = bus.a;
      s1_b_d      = bus.b;
      s1_mode_d   = bus.mode;
      s1_v_d      = bus.valid_in;
      valid_out_d = s1_v_q;
      if (s1_v_q) begin
        c_d        = res;
        carry_d    = res_carry;
        overflow_d = res_ovf;
        if (s1_mode_q[1]) begin
          acc_d = res;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= 2'b00;
      s1_v_q      <= 1'b0;
      c_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      s1_v_q      <= s1_v_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign bus.c         = c_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.valid_out = valid_out_q;
endmodule

// File: tb/tb_sumador_acumulador_pipe.sv
// Directed bench: a wrapping (dut0) and a saturating (dut1) 4-bit instance driven in lockstep.
module tb_sumador_acumulador_pipe;
  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   err_cnt;
  logic [WIDTH+1:0] exp_q[$];

  sumador_acumulador_pipe_if #(.WIDTH(WIDTH)) if0 ();
  sumador_acumulador_pipe_if #(.WIDTH(WIDTH)) if1 ();

  sumador_acumulador_pipe #(.WIDTH(WIDTH), .SATURATE(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  sumador_acumulador_pipe #(.WIDTH(WIDTH), .SATURATE(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic enb, input logic v, input logic [1:0] mode,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if0.enb = enb; if0.valid_in = v; if0.mode = mode; if0.a = a; if0.b = b;
    if1.enb = enb; if1.valid_in = v; if1.mode = mode; if1.a = a; if1.b = b;
  endtask

  task automatic issue(input logic [1:0] mode, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    drive(1'b1, 1'b1, mode, a, b);
    tick();
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 2'b00, '0, '0);
    tick();
  endtask

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard: expected {overflow, carry, c} of dut0 in issue order
  task automatic push_exp(input logic [WIDTH-1:0] c, input logic carry, input logic ovf);
    exp_q.push_back({ovf, carry, c});
  endtask

  task automatic sb_check(input string tag);
    logic [WIDTH+1:0] e;
    check({tag, "_valid"}, 32'(if0.valid_out), 32'd1);
    if (exp_q.size() == 0) begin
      err_cnt++;
      $display("FAIL %s: got result with empty expected queue", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_c"},   32'(if0.c),        32'(e[WIDTH-1:0]));
      check({tag, "_cy"},  32'(if0.carry),    32'(e[WIDTH]));
      check({tag, "_ov"},  32'(if0.overflow), 32'(e[WIDTH+1]));
    end
  endtask

  initial begin
    chk_cnt = 0;
    err_cnt = 0;
    drive(1'b0, 1'b0, 2'b00, '0, '0);
    rst = 1'b0;
    tick();
    tick();
    check("rst_c",     32'(if0.c),         32'd0);
    check("rst_carry", 32'(if0.carry),     32'd0);
    check("rst_ovf",   32'(if0.overflow),  32'd0);
    check("rst_valid", 32'(if0.valid_out), 32'd0);
    check("rst_valid1", 32'(if1.valid_out), 32'd0);
    rst = 1'b1;

    // basic add, one-cycle valid pulse
    push_exp(4'd7, 1'b0, 1'b0);
    issue(2'b00, 4'd5, 4'd2);
    idle();
    sb_check("add_5_2");
    idle();
    check("add_pulse", 32'(if0.valid_out), 32'd0);
    check("add_hold",  32'(if0.c),         32'd7);

    // wrap vs saturate
    push_exp(4'd0, 1'b1, 1'b0);
    issue(2'b00, 4'd15, 4'd1);
    idle();
    sb_check("add_15_1");
    check("sat_add_c",  32'(if1.c),     32'd15);
    check("sat_add_cy", 32'(if1.carry), 32'd1);

    // signed cases
    push_exp(4'd8, 1'b0, 1'b1);
    issue(2'b00, 4'd7, 4'd1);
    idle();
    sb_check("add_7_1");

    push_exp(4'd14, 1'b1, 1'b0);
    issue(2'b01, 4'd3, 4'd5);
    idle();
    sb_check("sub_3_5");
    check("sat_sub_c",  32'(if1.c),     32'd0);
    check("sat_sub_cy", 32'(if1.carry), 32'd1);

    push_exp(4'd7, 1'b0, 1'b1);
    issue(2'b01, 4'd8, 4'd1);
    idle();
    sb_check("sub_8_1");

    // back-to-back accumulate chain with an interleaved add
    push_exp(4'd3,  1'b0, 1'b0);
    push_exp(4'd7,  1'b0, 1'b0);
    push_exp(4'd12, 1'b0, 1'b1);
    push_exp(4'd5,  1'b1, 1'b1);
    push_exp(4'd2,  1'b0, 1'b0);
    push_exp(4'd6,  1'b0, 1'b0);
    issue(2'b11, 4'd3, 4'd0);
    issue(2'b10, 4'd4, 4'd0);
    sb_check("ld3");
    issue(2'b10, 4'd5, 4'd0);
    sb_check("acc7");
    issue(2'b10, 4'd9, 4'd0);
    sb_check("acc12");
    issue(2'b00, 4'd1, 4'd1);
    sb_check("acc5");
    check("sat_acc_c",  32'(if1.c),     32'd15);
    check("sat_acc_cy", 32'(if1.carry), 32'd1);
    issue(2'b10, 4'd1, 4'd0);
    sb_check("mid_add2");
    idle();
    sb_check("acc6");

    // stall: enable low for 3 edges with a valid_in that must be dropped
    push_exp(4'd7, 1'b0, 1'b0);
    issue(2'b00, 4'd5, 4'd2);
    drive(1'b0, 1'b1, 2'b00, 4'd1, 4'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(if0.valid_out), 32'd0);
      check("stall_c",     32'(if0.c),         32'd6);
    end
    drive(1'b1, 1'b0, 2'b00, '0, '0);
    tick();
    sb_check("stall_res");
    idle();
    check("stall_drop", 32'(if0.valid_out), 32'd0);

    // reset mid-operation with enable low
    push_exp(4'd12, 1'b0, 1'b0);
    issue(2'b11, 4'd12, 4'd0);
    idle();
    sb_check("ld12");
    issue(2'b00, 4'd1, 4'd1);
    drive(1'b0, 1'b0, 2'b00, '0, '0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_c",     32'(if0.c),         32'd0);
    check("mid_rst_carry", 32'(if0.carry),     32'd0);
    check("mid_rst_ovf",   32'(if0.overflow),  32'd0);
    check("mid_rst_valid", 32'(if0.valid_out), 32'd0);
    idle();
    check("rst_stale", 32'(if0.valid_out), 32'd0);
    push_exp(4'd4, 1'b0, 1'b0);
    issue(2'b10, 4'd4, 4'd0);
    idle();
    sb_check("acc_after_rst");

    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/sumador_acumulador_pipe.md
Name: sumador_acumulador_pipe

Overview:
- Parametrised successor to the team's 4-bit enabled adder: a WIDTH-bit add/subtract/accumulate unit with a two-stage pipeline and a valid handshake.
- Reports carry/borrow and signed overflow, and optionally saturates the result.
- Sits between stimulus/tester logic and downstream datapath consumers.
- Enable stalls the whole pipeline without losing data.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).
- SATURATE, 0, 1 = clamp unsigned results on carry/borrow; 0 = wrap modulo 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset.
- enb  input  1  pipeline enable; 0 = all registers hold.
- valid_in  input  1  a, b, mode carry a valid operation this cycle.
- mode  input  2  00 add a+b; 01 sub a-b; 10 accumulate acc+a; 11 load acc=a.
- a  input  WIDTH  operand A, unsigned / two's complement.
- b  input  WIDTH  operand B; ignored for modes 10 and 11.
- c  output  WIDTH  registered result.
- carry  output  1  add/acc: carry-out; sub: borrow (a<b unsigned); load: 0.
- overflow  output  1  signed two's-complement overflow of the operation; load: 0.
- valid_out  output  1  c/carry/overflow hold a new result.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. Reset is sampled only at posedge clk, and rst==0 has priority over enb.
- Reset values: c=0, carry=0, overflow=0, valid_out=0, acc=0, stage-1 valid=0, stage-1 operand registers=0.
- Stage 1 (posedge, enb=1): register a, b, mode and valid_in into s1_a, s1_b, s1_mode, s1_v.
- Stage 2 (posedge, enb=1): compute from the stage-1 registers (acc for modes 10/11), then register c, carry, overflow, and valid_out=s1_v.
- Latency: an operation sampled at edge N with enb=1 at edges N and N+1 appears at edge N+1, with valid_out=1 after that edge. This is 2 register stages: result visible the cycle after the second edge.
- Invalid slots: when s1_v=0 at stage 2, valid_out=0 and c/carry/overflow hold their previous values. acc is untouched.
- Arithmetic: compute a WIDTH+1-bit internal sum.
  - add: {carry,c}=a+b.
  - sub: a+~b+1, with carry = NOT carry-out (borrow).
  - acc: {carry,c}=acc+a.
  - overflow = operands' sign bits equal and result sign differs. For sub, compare a against ~b.
- Accumulator: on a valid 10 or 11 at stage 2, acc <= c_next (the same value driven to c). Modes 00/01 never modify acc.
- Back-to-back accumulates chain with no bubble, because acc is read and written in the same stage.
- SATURATE=1:
  - add/acc with carry=1: c = all ones.
  - sub with borrow=1: c = 0.
  - carry/overflow flags still report the unclamped condition.
  - acc stores the clamped value.
- SATURATE=0: c wraps modulo 2^WIDTH.
- Stall: enb=0 at an edge holds every register (s1_*, acc, c, carry, overflow, valid_out). A valid_in presented during a stall cycle is not captured.
- Reset mid-operation: in-flight stage-1 contents are discarded; no valid_out pulses for them after reset deasserts.
- Reset with enb=0: reset still takes effect.
- Width rules: no sign/zero extension at ports; outputs are exactly WIDTH bits.

Test Plan (WIDTH=4 unless noted):
- Add: a=5, b=2, mode=00, valid_in=1, enb=1 -> 2 edges later c=7, carry=0, overflow=0, valid_out=1 for one cycle.
- Wrap vs saturate: a=15, b=1, add.
  - SATURATE=0 -> c=0, carry=1, overflow=0.
  - SATURATE=1 -> c=15, carry=1.
  - Sub a=3, b=5 with SATURATE=1 -> c=0, carry=1.
- Signed cases:
  - add a=7, b=1 -> c=8, overflow=1, carry=0.
  - sub a=3, b=5 (SATURATE=0) -> c=14, carry=1, overflow=0.
  - sub a=8, b=1 -> c=7, overflow=1.
- Accumulate chain: consecutive cycles load 3 (mode 11), acc 4, acc 5, acc 9 -> c=3, 7, 12, 5 with carry=1 on the last. Interleaved add 1+1 in the chain -> c=2, acc unchanged.
- Stall: issue add 5+2, drop enb for 3 cycles after the first edge, then raise it -> c/valid_out frozen during the stall; result 7 appears exactly 1 enabled edge later; a valid_in presented during the stall yields no result.
- Reset: with an add in stage 1 and acc=12, drive rst=0 for 1 edge (enb=0) -> c=0, carry=0, overflow=0, valid_out=0, acc=0. No stale valid_out afterwards; a following acc 4 gives c=4.
